bg_win_fetcher: RTL and testbench

- Successor to the mode-3 background tile fetcher. Fetches background and window tiles, and in CGB mode also the attribute byte.
- Applies CGB flips and palette, then pushes 8-pixel rows into the BG FIFO.
- VRAM access uses a valid-qualified request/response handshake, so arbitration stalls of any length are tolerated.
- Sits between the PPU mode sequencer, the VRAM arbiter and the BG pixel FIFO.

---
 rtl/ppu_types_pkg.sv | 36 +++
 rtl/ppu_util_pkg.sv | 42 ++++
 rtl/tile_row_unpack.sv | 17 +
 rtl/bg_win_fetcher.sv | 216 +++++++++++++++++++++
 tb/tb_bg_win_fetcher.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ppu_types_pkg.sv
// rtl/ppu_types_pkg.sv - shared PPU types and VRAM layout constants
package ppu_types_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_TILE,
        ST_GET_ATTR,
        ST_GET_LOW,
        ST_GET_HIGH,
        ST_PUSH
    } fetcher_state_t;

    typedef struct packed {
        logic       bg_prio;
        logic [2:0] palette;
        logic [1:0] color;
    } bg_pixel_t;

    // Bit layout matches the CGB attribute byte, MSB first.
    typedef struct packed {
        logic       prio;
        logic       yflip;
        logic       xflip;
        logic       pal_hi;
        logic       bank;
        logic [2:0] pal;
    } tile_attr_t;

    localparam logic [12:0] MAP_BASE_LO      = 13'h1800;
    localparam logic [12:0] MAP_BASE_HI      = 13'h1C00;
    localparam logic [12:0] DATA_BASE_SIGNED = 13'h1000;

    localparam int TILE_PIXELS = 8;
    localparam int PIXEL_W     = 6;

endpackage

// File: rtl/ppu_util_pkg.sv
// rtl/ppu_util_pkg.sv - tile data addressing and row unpacking helpers
package ppu_util_pkg;
    import ppu_types_pkg::*;

    // Byte address of one bitplane of a tile row; all arithmetic wraps at 13 bits.
    function automatic logic [12:0] tile_data_addr(
        input logic [7:0] tid,
        input logic [2:0] row,
        input logic       unsigned_mode,
        input logic       hi_byte
    );
        logic [12:0] off;
        off = {9'd0, row, hi_byte};
        if (unsigned_mode) begin
            return {1'b0, tid, 4'd0} + off;
        end
        return DATA_BASE_SIGNED + {tid[7], tid, 4'd0} + off;
    endfunction

    // Slot 0 is the leftmost pixel, i.e. bit 7 of each plane unless flipped.
    function automatic logic [TILE_PIXELS*PIXEL_W-1:0] unpack_row(
        input logic [7:0] low,
        input logic [7:0] high,
        input tile_attr_t attr
    );
        logic [TILE_PIXELS*PIXEL_W-1:0] row;
        bg_pixel_t                      px;
        row = '0;
        for (int i = 0; i < TILE_PIXELS; i++) begin
            px.bg_prio = attr.prio;
            px.palette = attr.pal;
            if (attr.xflip) begin
                px.color = {high[i], low[i]};
            end else begin
                px.color = {high[7-i], low[7-i]};
            end
            row[i*PIXEL_W +: PIXEL_W] = px;
        end
        return row;
    endfunction

endpackage

// File: rtl/tile_row_unpack.sv
// rtl/tile_row_unpack.sv - combinational tile row to FIFO push word
module tile_row_unpack
    import ppu_types_pkg::*;
    import ppu_util_pkg::*;
(
    input  logic [7:0]                       low,
    input  logic [7:0]                       high,
    input  tile_attr_t                       attr,
    output logic [TILE_PIXELS*PIXEL_W-1:0]   row_data
);

    // Apply flip, palette and priority to the two bitplanes.
    always_comb begin
        row_data = unpack_row(low, high, attr);
    end

endmodule

// File: rtl/bg_win_fetcher.sv
// rtl/bg_win_fetcher.sv - background/window tile fetcher feeding the BG FIFO
module bg_win_fetcher
    import ppu_types_pkg::*;
    import ppu_util_pkg::*;
#(
    parameter int VRAM_AW     = 13,
    parameter int MAP_W_LOG2  = 5,
    parameter int PUSH_PIXELS = 8,
    parameter int CGB_EN      = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     win_start,
    input  logic                     cgb_mode,
    input  logic [7:0]               lcdc,
    input  logic [7:0]               scx,
    input  logic [7:0]               scy,
    input  logic [7:0]               ly,
    input  logic [7:0]               win_line,
    output logic                     rd_req,
    output logic [VRAM_AW-1:0]       rd_addr,
    output logic                     rd_bank,
    input  logic                     rd_valid,
    input  logic [7:0]               rd_data,
    input  logic                     fifo_empty,
    output logic                     push,
    output logic [PUSH_PIXELS*6-1:0] push_data,
    output logic                     window_active,
    output logic [MAP_W_LOG2-1:0]    fetch_x
);

    fetcher_state_t               state_q, state_d;
    logic                         rd_req_q, rd_req_d;
    logic [VRAM_AW-1:0]           rd_addr_q, rd_addr_d;
    logic                         rd_bank_q, rd_bank_d;
    logic [7:0]                   tile_q, tile_d;
    tile_attr_t                   attr_q, attr_d;
    logic [7:0]                   low_q, low_d;
    logic [7:0]                   high_q, high_d;
    logic                         push_q, push_d;
    logic [PUSH_PIXELS*6-1:0]     push_data_q, push_data_d;
    logic                         window_active_q, window_active_d;
    logic [MAP_W_LOG2-1:0]        fetch_x_q, fetch_x_d;

    logic [7:0]                   y_sel;
    logic [12:0]                  map_base;
    logic [12:0]                  map_addr;
    logic [2:0]                   tile_row;
    logic [12:0]                  data_lo_addr;
    logic [12:0]                  data_hi_addr;
    logic [TILE_PIXELS*PIXEL_W-1:0] row_data;
    logic                         attr_fetch_en;
    logic                         unused_bits;

    assign unused_bits   = ^{lcdc[7], lcdc[5], lcdc[2:0], scx[2:0]};
    assign attr_fetch_en = (CGB_EN != 0) && cgb_mode;

    // Live address terms; only sampled into rd_addr_q on entry to a fetch state.
    always_comb begin
        y_sel        = window_active_q ? win_line : scy + ly;
        map_base     = (window_active_q ? lcdc[6] : lcdc[3]) ? MAP_BASE_HI : MAP_BASE_LO;
        map_addr     = map_base + {3'b000, y_sel[7:3], 5'b00000} + 13'(fetch_x_q);
        tile_row     = attr_q.yflip ? ~y_sel[2:0] : y_sel[2:0];
        data_lo_addr = tile_data_addr(tile_q, tile_row, lcdc[4], 1'b0);
        data_hi_addr = tile_data_addr(tile_q, tile_row, lcdc[4], 1'b1);
    end

    tile_row_unpack u_unpack (
        .low      (low_q),
        .high     (high_q),
        .attr     (attr_q),
        .row_data (row_data)
    );

    // Next-state logic: per-state read handshake, then abort/restart overrides.
    always_comb begin
        state_d         = state_q;
        rd_req_d        = rd_req_q;
        rd_addr_d       = rd_addr_q;
        rd_bank_d       = rd_bank_q;
        tile_d          = tile_q;
        attr_d          = attr_q;
        low_d           = low_q;
        high_d          = high_q;
        push_d          = 1'b0;
        push_data_d     = push_data_q;
        window_active_d = window_active_q;
        fetch_x_d       = fetch_x_q;

        case (state_q)
            ST_IDLE: begin
            end
            ST_GET_TILE: begin
                if (!rd_req_q) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = VRAM_AW'(map_addr);
                    rd_bank_d = 1'b0;
                end else if (rd_valid) begin
                    rd_req_d = 1'b0;
                    tile_d   = rd_data;
                    attr_d   = '0;
                    state_d  = attr_fetch_en ? ST_GET_ATTR : ST_GET_LOW;
                end
            end
            ST_GET_ATTR: begin
                if (!rd_req_q) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = VRAM_AW'(map_addr);
                    rd_bank_d = 1'b1;
                end else if (rd_valid) begin
                    rd_req_d = 1'b0;
                    attr_d   = rd_data;
                    state_d  = ST_GET_LOW;
                end
            end
            ST_GET_LOW: begin
                if (!rd_req_q) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = VRAM_AW'(data_lo_addr);
                    rd_bank_d = attr_q.bank;
                end else if (rd_valid) begin
                    rd_req_d = 1'b0;
                    low_d    = rd_data;
                    state_d  = ST_GET_HIGH;
                end
            end
            ST_GET_HIGH: begin
                if (!rd_req_q) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = VRAM_AW'(data_hi_addr);
                    rd_bank_d = attr_q.bank;
                end else if (rd_valid) begin
                    rd_req_d = 1'b0;
                    high_d   = rd_data;
                    state_d  = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (fifo_empty) begin
                    push_d      = 1'b1;
                    push_data_d = row_data;
                    fetch_x_d   = fetch_x_q + MAP_W_LOG2'(1);
                    state_d     = ST_GET_TILE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rd_req_d = 1'b0;
            end
        endcase

        // Lowest priority override first so later ones win.
        if (start) begin
            state_d         = ST_GET_TILE;
            rd_req_d        = 1'b0;
            push_d          = 1'b0;
            window_active_d = 1'b0;
            fetch_x_d       = MAP_W_LOG2'(scx[7:3]);
        end
        if (win_start && (state_q != ST_IDLE)) begin
            state_d         = ST_GET_TILE;
            rd_req_d        = 1'b0;
            push_d          = 1'b0;
            window_active_d = 1'b1;
            fetch_x_d       = '0;
        end
        if (stop) begin
            state_d         = ST_IDLE;
            rd_req_d        = 1'b0;
            push_d          = 1'b0;
            window_active_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            rd_req_q        <= 1'b0;
            rd_addr_q       <= '0;
            rd_bank_q       <= 1'b0;
            tile_q          <= '0;
            attr_q          <= '0;
            low_q           <= '0;
            high_q          <= '0;
            push_q          <= 1'b0;
            push_data_q     <= '0;
            window_active_q <= 1'b0;
            fetch_x_q       <= '0;
        end else begin
            state_q         <= state_d;
            rd_req_q        <= rd_req_d;
            rd_addr_q       <= rd_addr_d;
            rd_bank_q       <= rd_bank_d;
            tile_q          <= tile_d;
            attr_q          <= attr_d;
            low_q           <= low_d;
            high_q          <= high_d;
            push_q          <= push_d;
            push_data_q     <= push_data_d;
            window_active_q <= window_active_d;
            fetch_x_q       <= fetch_x_d;
        end
    end

    assign rd_req        = rd_req_q;
    assign rd_addr       = rd_addr_q;
    assign rd_bank       = rd_bank_q;
    assign push          = push_q;
    assign push_data     = push_data_q;
    assign window_active = window_active_q;
    assign fetch_x       = fetch_x_q;

endmodule

// File: tb/tb_bg_win_fetcher.sv
// tb/tb_bg_win_fetcher.sv - directed vector bench for bg_win_fetcher
module tb_bg_win_fetcher;

    logic        clk = 1'b0;
    logic        reset_n, start, stop, win_start, cgb_mode;
    logic [7:0]  lcdc, scx, scy, ly, win_line;
    logic        rd_req, rd_bank, rd_valid, fifo_empty, push, window_active;
    logic [12:0] rd_addr;
    logic [7:0]  rd_data;
    logic [47:0] push_data;
    logic [4:0]  fetch_x;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bg_win_fetcher dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .win_start     (win_start),
        .cgb_mode      (cgb_mode),
        .lcdc          (lcdc),
        .scx           (scx),
        .scy           (scy),
        .ly            (ly),
        .win_line      (win_line),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_bank       (rd_bank),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fifo_empty    (fifo_empty),
        .push          (push),
        .push_data     (push_data),
        .window_active (window_active),
        .fetch_x       (fetch_x)
    );

    typedef struct packed {
        logic [7:0]  lcdc;
        logic [7:0]  scx;
        logic [7:0]  scy;
        logic [7:0]  ly;
        logic        cgb;
        logic [12:0] map_a;
        logic [7:0]  tile;
        logic [7:0]  attr;
        logic [12:0] lo_a;
        logic        dbank;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [3:0]  delay;
        logic [3:0]  fe_hold;
        logic [15:0] colors;
        logic [2:0]  pal;
        logic        prio;
        logic [4:0]  fx_after;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] pack_row(input logic [15:0] colors, input logic [2:0] pal,
                                             input logic prio);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*6 +: 6] = {prio, pal, colors[i*2 +: 2]};
        return r;
    endfunction

    task automatic serve_read(input string name, input logic [12:0] exp_addr, input logic exp_bank,
                              input logic [7:0] data, input int delay);
        int n;
        n = 0;
        while (!rd_req && n < 20) begin
            tick();
            n++;
        end
        check({name, " req"}, rd_req, 1);
        check({name, " addr"}, rd_addr, exp_addr);
        check({name, " bank"}, rd_bank, exp_bank);
        for (int d = 0; d < delay; d++) begin
            tick();
            check({name, " stall req"}, rd_req, 1);
            check({name, " stall addr"}, rd_addr, exp_addr);
        end
        rd_valid = 1'b1;
        rd_data  = data;
        tick();
        rd_valid = 1'b0;
        check({name, " req drop"}, rd_req, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; win_start = 1'b0; cgb_mode = 1'b0;
        lcdc = 8'h00; scx = 8'h00; scy = 8'h00; ly = 8'h00; win_line = 8'h00;
        rd_valid = 1'b0; rd_data = 8'h00; fifo_empty = 1'b1;

        vecs[0] = '{8'h91, 8'h13, 8'h05, 8'h02, 1'b0, 13'h1802, 8'h04, 8'h00, 13'h004E, 1'b0,
                    8'hF0, 8'h0F, 4'd0, 4'd0, 16'hAA55, 3'd0, 1'b0, 5'd3};
        vecs[1] = '{8'h81, 8'h00, 8'h00, 8'h00, 1'b0, 13'h1800, 8'h80, 8'h00, 13'h0800, 1'b0,
                    8'h81, 8'h00, 4'd1, 4'd0, 16'h4001, 3'd0, 1'b0, 5'd1};
        vecs[2] = '{8'h89, 8'hF8, 8'h10, 8'h00, 1'b0, 13'h1C5F, 8'h7F, 8'h00, 13'h17F0, 1'b0,
                    8'h00, 8'hFF, 4'd5, 4'd3, 16'hAAAA, 3'd0, 1'b0, 5'd0};
        vecs[3] = '{8'h91, 8'h08, 8'h00, 8'h21, 1'b1, 13'h1881, 8'h10, 8'h6B, 13'h010C, 1'b1,
                    8'hF0, 8'h0F, 4'd2, 4'd0, 16'h55AA, 3'd3, 1'b0, 5'd2};
        vecs[4] = '{8'h91, 8'h00, 8'h03, 8'h04, 1'b1, 13'h1800, 8'h02, 8'h85, 13'h002E, 1'b0,
                    8'h3C, 8'h5A, 4'd0, 4'd1, 16'h27D8, 3'd5, 1'b1, 5'd1};

        #3;
        check("reset rd_req", rd_req, 0);
        check("reset push", push, 0);
        check("reset window_active", window_active, 0);
        check("reset fetch_x", fetch_x, 0);
        check("reset push_data", push_data, 0);
        #9 reset_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            lcdc = vecs[v].lcdc; scx = vecs[v].scx; scy = vecs[v].scy; ly = vecs[v].ly;
            cgb_mode   = vecs[v].cgb;
            fifo_empty = (vecs[v].fe_hold == 0);
            start = 1'b1; tick(); start = 1'b0;
            serve_read($sformatf("v%0d map", v), vecs[v].map_a, 1'b0, vecs[v].tile, vecs[v].delay);
            if (vecs[v].cgb)
                serve_read($sformatf("v%0d attr", v), vecs[v].map_a, 1'b1, vecs[v].attr, vecs[v].delay);
            serve_read($sformatf("v%0d low", v), vecs[v].lo_a, vecs[v].dbank, vecs[v].lo, vecs[v].delay);
            serve_read($sformatf("v%0d high", v), vecs[v].lo_a | 13'h1, vecs[v].dbank, vecs[v].hi,
                       vecs[v].delay);
            for (int h = 0; h < vecs[v].fe_hold; h++) begin
                check($sformatf("v%0d push held", v), push, 0);
                tick();
            end
            fifo_empty = 1'b1;
            tick();
            check($sformatf("v%0d push", v), push, 1);
            check($sformatf("v%0d push_data", v), push_data,
                  pack_row(vecs[v].colors, vecs[v].pal, vecs[v].prio));
            check($sformatf("v%0d fetch_x", v), fetch_x, vecs[v].fx_after);
            check($sformatf("v%0d window_active", v), window_active, 0);
            tick();
            check($sformatf("v%0d push one cycle", v), push, 0);
            check($sformatf("v%0d next fetch req", v), rd_req, 1);
            stop = 1'b1; tick(); stop = 1'b0; tick();
            check($sformatf("v%0d stop idle", v), rd_req, 0);
        end

        // Window switch in the middle of a low-byte fetch, then a stray rd_valid.
        lcdc = 8'hD1; scx = 8'h00; scy = 8'h00; ly = 8'h00; win_line = 8'd9; cgb_mode = 1'b0;
        fifo_empty = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        serve_read("win bg map", 13'h1800, 1'b0, 8'h01, 0);
        tick();
        check("win bg low req", rd_req, 1);
        check("win bg low addr", rd_addr, 13'h0010);
        win_start = 1'b1; tick(); win_start = 1'b0;
        check("win abort req", rd_req, 0);
        check("win active", window_active, 1);
        check("win fetch_x", fetch_x, 0);
        rd_valid = 1'b1; rd_data = 8'hEE; tick(); rd_valid = 1'b0;
        serve_read("win map", 13'h1C20, 1'b0, 8'h00, 0);
        serve_read("win low", 13'h0002, 1'b0, 8'hFF, 0);
        serve_read("win high", 13'h0003, 1'b0, 8'hFF, 0);
        tick();
        check("win push", push, 1);
        check("win push_data", push_data, pack_row(16'hFFFF, 3'd0, 1'b0));
        check("win fetch_x after", fetch_x, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("win stop clears", window_active, 0);

        // Simultaneous pulses from IDLE.
        lcdc = 8'h91; scx = 8'h13; scy = 8'h05; ly = 8'h02;
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick();
        check("stop beats start", rd_req, 0);
        start = 1'b1; win_start = 1'b1; tick(); start = 1'b0; win_start = 1'b0; tick();
        check("idle win ignored req", rd_req, 1);
        check("idle win ignored addr", rd_addr, 13'h1802);
        check("idle win ignored active", window_active, 0);

        // Asynchronous reset while a read is outstanding.
        reset_n = 1'b0;
        #1;
        check("async reset rd_req", rd_req, 0);
        check("async reset fetch_x", fetch_x, 0);
        check("async reset push_data", push_data, 0);
        check("async reset rd_addr", rd_addr, 0);
        #2 reset_n = 1'b1;
        tick();
        tick();
        check("post reset idle", rd_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
